chip8_call_ret_ctrl: RTL

//  Sequencer for the 16x16 call/return stack. Accepts CALL (2nnn) and RET (00EE) requests from the
//  CPU decode stage, drives the stack's push/pop strobes, and returns the next PC. Tracks stack depth,

---
 rtl/chip8_pkg.sv | 30 +++
 rtl/chip8_stack.sv | 37 +++
 rtl/chip8_call_ret_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/chip8_pkg.sv
// Shared types and constants for the CHIP-8 call/return path: stack strobe
// encoding, call/return controller states, request opcodes and fault codes.
package chip8_pkg;

  // Stack strobe encoding; 2'b11 is never driven.
  typedef enum logic [1:0] {
    STK_NOP  = 2'b00,
    STK_PUSH = 2'b01,
    STK_POP  = 2'b10
  } stk_op_t;

  // Call/return controller states.
  typedef enum logic [2:0] {
    IDLE,
    PUSH,
    POP,
    POP_WAIT,
    DONE
  } ctrl_state_t;

  // Request opcode carried on req_op.
  localparam logic OP_CALL = 1'b0;
  localparam logic OP_RET  = 1'b1;

  // Sticky fault codes.
  localparam logic [1:0] FAULT_NONE = 2'b00;
  localparam logic [1:0] FAULT_OVF  = 2'b01;
  localparam logic [1:0] FAULT_UNF  = 2'b10;

endpackage

// File: rtl/chip8_stack.sv
// 16-entry return-address stack RAM. It has no pointer and no reset: the
// controller's depth count is the address, so push writes entry [depth] and
// pop reads entry [depth-1] into a registered read port.
module chip8_stack
  import chip8_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int PC_W  = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk_i,
  input  stk_op_t         op_i,
  input  logic [AW-1:0]   addr_i,
  input  logic [PC_W-1:0] wdata_i,
  output logic [PC_W-1:0] rdata_o
);

  logic [PC_W-1:0] mem [DEPTH];
  logic [AW-1:0]   rd_idx;

  // Pop reads one below the occupancy count; at a full stack the count's
  // low bits wrap to 0 and the subtraction wraps back to the top entry.
  always_comb begin
    rd_idx = addr_i - AW'(1);
  end

  // Write on push, registered read on pop.
  always_ff @(posedge clk_i) begin
    if (op_i == STK_PUSH) begin
      mem[addr_i] <= wdata_i;
    end
    if (op_i == STK_POP) begin
      rdata_o <= mem[rd_idx];
    end
  end

endmodule

// File: rtl/chip8_call_ret_ctrl.sv
// Call/return sequencer for the CHIP-8 CPU. Takes CALL (2nnn) and RET (00EE)
// requests from decode, strobes the stack, returns the next PC, tracks depth
// and raises sticky overflow/underflow faults without touching the stack.
//
// Handshake: req_ready is high only in IDLE; a request is taken on a rising
// edge where req_valid && req_ready, and req_valid is ignored at every other
// time. Completion is a one-cycle done pulse with new_pc valid and held until
// the next done.
module chip8_call_ret_ctrl
  import chip8_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int PC_W    = 16,
  parameter int PC_STEP = 2
) (
  input  logic            cpu_clk,
  input  logic            reset_n,
  input  logic            req_valid,
  input  logic            req_op,
  input  logic [PC_W-1:0] pc_in,
  input  logic [11:0]     target_addr,
  output logic            req_ready,
  output logic            done,
  output logic [PC_W-1:0] new_pc,
  output logic            fault,
  output logic [1:0]      fault_code,
  input  logic            clear_fault,
  output logic [4:0]      depth,
  output stk_op_t         stk_we,
  output logic [PC_W-1:0] stk_wdata,
  input  logic [PC_W-1:0] stk_rdata,
  output ctrl_state_t     dbg_state
);

  localparam logic [4:0] DEPTH_MAX = 5'(DEPTH);

  ctrl_state_t     state_q, state_d;
  logic [4:0]      depth_q, depth_d;
  logic [PC_W-1:0] new_pc_q, new_pc_d;
  logic [PC_W-1:0] wdata_q, wdata_d;
  logic [11:0]     target_q, target_d;
  logic            fault_q, fault_d;
  logic [1:0]      code_q, code_d;

  logic            is_call;
  logic            full;
  logic            empty;
  logic [PC_W-1:0] ret_addr;

  // Request decode and occupancy flags.
  always_comb begin
    is_call  = (req_op == OP_CALL);
    full     = (depth_q == DEPTH_MAX);
    empty    = (depth_q == 5'd0);
    ret_addr = pc_in + PC_W'(PC_STEP);
  end

  // State register; reset abandons any operation in flight.
  always_ff @(posedge cpu_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: faults skip straight to DONE so the stack is never touched.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (is_call) begin
            state_d = full ? DONE : PUSH;
          end else begin
            state_d = empty ? DONE : POP;
          end
        end
      end
      PUSH:     state_d = DONE;
      POP:      state_d = POP_WAIT;
      POP_WAIT: state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; the stack is strobed only in PUSH/POP.
  always_comb begin
    req_ready = (state_q == IDLE);
    done      = (state_q == DONE);
    case (state_q)
      PUSH:    stk_we = STK_PUSH;
      POP:     stk_we = STK_POP;
      default: stk_we = STK_NOP;
    endcase
    dbg_state  = state_q;
    depth      = depth_q;
    new_pc     = new_pc_q;
    fault      = fault_q;
    fault_code = code_q;
    stk_wdata  = wdata_q;
  end

  // Datapath next-state. clear_fault is applied first so a fault raised on
  // the same edge overrides it.
  always_comb begin
    depth_d  = depth_q;
    new_pc_d = new_pc_q;
    wdata_d  = wdata_q;
    target_d = target_q;
    fault_d  = fault_q;
    code_d   = code_q;

    if (clear_fault) begin
      fault_d = 1'b0;
      code_d  = FAULT_NONE;
    end

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (is_call) begin
            if (full) begin
              fault_d  = 1'b1;
              code_d   = FAULT_OVF;
              new_pc_d = ret_addr;
            end else begin
              wdata_d  = ret_addr;
              target_d = target_addr;
            end
          end else if (empty) begin
            fault_d  = 1'b1;
            code_d   = FAULT_UNF;
            new_pc_d = ret_addr;
          end
        end
      end
      PUSH: begin
        depth_d  = depth_q + 5'd1;
        new_pc_d = {{(PC_W-12){1'b0}}, target_q};
      end
      POP: begin
        depth_d = depth_q - 5'd1;
      end
      POP_WAIT: begin
        new_pc_d = stk_rdata;
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge cpu_clk or negedge reset_n) begin
    if (!reset_n) begin
      depth_q  <= 5'd0;
      new_pc_q <= '0;
      wdata_q  <= '0;
      target_q <= '0;
      fault_q  <= 1'b0;
      code_q   <= FAULT_NONE;
    end else begin
      depth_q  <= depth_d;
      new_pc_q <= new_pc_d;
      wdata_q  <= wdata_d;
      target_q <= target_d;
      fault_q  <= fault_d;
      code_q   <= code_d;
    end
  end

endmodule
